// File: rtl/buf_tag_dir_pkg.sv
// Shared constants and FSM state type for the buffer tag directory.
// The buffer count is tied to the downstream LFU replacement unit.
package buf_tag_dir_pkg;
  localparam int NUM_BUF = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    WAIT    = 2'd2,
    INSTALL = 2'd3
  } state_t;
endpackage

// File: rtl/buf_tag_match.sv
// Combinational tag compare across all buffers.
// Produces the lowest hitting index and the lowest free index.
module buf_tag_match
  import buf_tag_dir_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic [TAG_W-1:0] tags [NUM_BUF],
  input  logic [NUM_BUF-1:0] valid,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic             any_free,
  output logic [IDX_W-1:0] free_idx
);

  // Scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/buf_tag_dir.sv
// Buffer tag directory: matches requests against resident tags, fills free
// buffers first and otherwise asks the LFU for a victim to replace.
module buf_tag_dir
  import buf_tag_dir_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_buf,
  output logic             ref_valid,
  output logic [IDX_W-1:0] ref_buf_numbr,
  output logic             new_buf_req,
  input  logic [IDX_W-1:0] buf_num_replc,
  output logic             fill_valid,
  output logic [IDX_W-1:0] fill_buf,
  output logic [TAG_W-1:0] fill_tag,
  output logic             fill_evict,
  output logic [TAG_W-1:0] fill_old_tag
);

  state_t             state;
  logic [TAG_W-1:0]   tags [NUM_BUF];
  logic [NUM_BUF-1:0] valid;
  logic [TAG_W-1:0]   lat_tag;
  logic [IDX_W-1:0]   victim;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             any_free;
  logic [IDX_W-1:0] free_idx;

  buf_tag_match #(.TAG_W(TAG_W)) u_match (
    .tags       (tags),
    .valid      (valid),
    .lookup_tag (lat_tag),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .any_free   (any_free),
    .free_idx   (free_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      lat_tag       <= '0;
      victim        <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_buf      <= '0;
      ref_valid     <= 1'b0;
      ref_buf_numbr <= '0;
      new_buf_req   <= 1'b0;
      fill_valid    <= 1'b0;
      fill_buf      <= '0;
      fill_tag      <= '0;
      fill_evict    <= 1'b0;
      fill_old_tag  <= '0;
    end else begin
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_buf     <= '0;
      ref_valid    <= 1'b0;
      new_buf_req  <= 1'b0;
      fill_valid   <= 1'b0;
      fill_buf     <= '0;
      fill_tag     <= '0;
      fill_evict   <= 1'b0;
      fill_old_tag <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_tag   <= req_tag;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid    <= 1'b1;
            resp_hit      <= 1'b1;
            resp_buf      <= hit_idx;
            ref_valid     <= 1'b1;
            ref_buf_numbr <= hit_idx;
            req_ready     <= 1'b1;
            state         <= IDLE;
          end else if (any_free) begin
            victim <= free_idx;
            state  <= INSTALL;
          end else begin
            new_buf_req <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // LFU answers while new_buf_req is visible.
          victim <= buf_num_replc;
          state  <= INSTALL;
        end
        INSTALL: begin
          tags[victim]  <= lat_tag;
          valid[victim] <= 1'b1;
          fill_valid    <= 1'b1;
          fill_buf      <= victim;
          fill_tag      <= lat_tag;
          fill_evict    <= valid[victim];
          fill_old_tag  <= valid[victim] ? tags[victim] : '0;
          ref_valid     <= 1'b1;
          ref_buf_numbr <= victim;
          resp_valid    <= 1'b1;
          resp_buf      <= victim;
          req_ready     <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buf_tag_dir.sv
// Randomised and directed bench for buf_tag_dir against a transaction-level
// directory model that predicts each output cycle from request latencies.
module tb_buf_tag_dir;
  import buf_tag_dir_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_tag = 8'h00;
  logic       req_ready;
  logic       resp_valid;
  logic       resp_hit;
  logic [1:0] resp_buf;
  logic       ref_valid;
  logic [1:0] ref_buf_numbr;
  logic       new_buf_req;
  logic [1:0] buf_num_replc = 2'd0;
  logic       fill_valid;
  logic [1:0] fill_buf;
  logic [7:0] fill_tag;
  logic       fill_evict;
  logic [7:0] fill_old_tag;

  buf_tag_dir #(.TAG_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_tag       (req_tag),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_buf      (resp_buf),
    .ref_valid     (ref_valid),
    .ref_buf_numbr (ref_buf_numbr),
    .new_buf_req   (new_buf_req),
    .buf_num_replc (buf_num_replc),
    .fill_valid    (fill_valid),
    .fill_buf      (fill_buf),
    .fill_tag      (fill_tag),
    .fill_evict    (fill_evict),
    .fill_old_tag  (fill_old_tag)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nbr_count = 0;
  int fill_count = 0;
  int ref_count = 0;
  int replc_fixed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // LFU stub: fixed victim for directed tests, random otherwise.
  always @(posedge clk) begin
    #2;
    if (replc_fixed >= 0) buf_num_replc = replc_fixed[1:0];
    else buf_num_replc = 2'($urandom_range(0, 3));
  end

  always @(negedge clk) begin
    if (new_buf_req === 1'b1) nbr_count++;
    if (fill_valid === 1'b1) fill_count++;
    if (ref_valid === 1'b1) ref_count++;
  end

  // ---------------- behavioural model ----------------
  // kind: 0 idle, 1 hit (response 1 edge after accept), 2 fill free (2),
  // 3 evict (LFU asked at +1, victim taken at +2, response at +3).
  logic [7:0] m_tag [4];
  logic       m_val [4];
  int         m_kind = 0;
  int         m_t = 0;
  int         m_idx = 0;
  logic [7:0] m_req;
  bit         model_live = 0;

  logic       e_ready, e_resp_valid, e_resp_hit, e_ref_valid, e_nbr;
  logic       e_fill_valid, e_fill_evict;
  logic [1:0] e_resp_buf, e_ref_num, e_fill_buf;
  logic [7:0] e_fill_tag, e_fill_old;

  always @(posedge clk) begin
    e_resp_valid = 0; e_resp_hit = 0; e_resp_buf = 0; e_ref_valid = 0; e_nbr = 0;
    e_fill_valid = 0; e_fill_buf = 0; e_fill_tag = 0; e_fill_evict = 0; e_fill_old = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
      m_kind = 0;
      e_ready = 1;
      e_ref_num = 0;
    end else if (m_kind != 0) begin
      m_t++;
      if (m_kind == 1 && m_t == 1) begin
        e_resp_valid = 1; e_resp_hit = 1; e_resp_buf = 2'(m_idx);
        e_ref_valid = 1; e_ref_num = 2'(m_idx);
        m_kind = 0; e_ready = 1;
      end else if (m_kind == 3 && m_t == 1) begin
        e_nbr = 1;
      end else if (m_kind == 3 && m_t == 2) begin
        m_idx = int'(buf_num_replc);
      end else if ((m_kind == 2 && m_t == 2) || (m_kind == 3 && m_t == 3)) begin
        e_fill_valid = 1; e_fill_buf = 2'(m_idx); e_fill_tag = m_req;
        e_fill_evict = m_val[m_idx];
        e_fill_old = m_val[m_idx] ? m_tag[m_idx] : 8'h00;
        m_tag[m_idx] = m_req; m_val[m_idx] = 1'b1;
        e_ref_valid = 1; e_ref_num = 2'(m_idx);
        e_resp_valid = 1; e_resp_buf = 2'(m_idx);
        m_kind = 0; e_ready = 1;
      end
    end else if (req_valid) begin
      m_req = req_tag; m_t = 0; e_ready = 0;
      m_kind = 0;
      for (int i = 0; i < 4 && m_kind == 0; i++)
        if (m_val[i] && m_tag[i] == m_req) begin m_kind = 1; m_idx = i; end
      for (int i = 0; i < 4 && m_kind == 0; i++)
        if (!m_val[i]) begin m_kind = 2; m_idx = i; end
      if (m_kind == 0) m_kind = 3;
    end
    model_live = 1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
      check("ref_valid", 32'(ref_valid), 32'(e_ref_valid));
      check("ref_buf_numbr", 32'(ref_buf_numbr), 32'(e_ref_num));
      check("new_buf_req", 32'(new_buf_req), 32'(e_nbr));
      check("fill_valid", 32'(fill_valid), 32'(e_fill_valid));
      if (e_resp_valid) begin
        check("resp_hit", 32'(resp_hit), 32'(e_resp_hit));
        check("resp_buf", 32'(resp_buf), 32'(e_resp_buf));
      end
      if (e_fill_valid) begin
        check("fill_buf", 32'(fill_buf), 32'(e_fill_buf));
        check("fill_tag", 32'(fill_tag), 32'(e_fill_tag));
        check("fill_evict", 32'(fill_evict), 32'(e_fill_evict));
        check("fill_old_tag", 32'(fill_old_tag), 32'(e_fill_old));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_req(input logic [7:0] tag, output logic hit, output logic [1:0] bidx,
                        output int lat, output logic ev, output logic [7:0] old);
    int n;
    @(posedge clk); #2;
    req_valid = 1'b1; req_tag = tag; n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #2;
    req_valid = 1'b0;
    lat = 0;
    do begin
      lat++;
      if (resp_valid !== 1'b1) begin @(posedge clk); #2; end
    end while (resp_valid !== 1'b1 && lat < 10);
    check("resp_timeout", 32'(resp_valid), 32'd1);
    hit = resp_hit; bidx = resp_buf; ev = fill_evict; old = fill_old_tag;
  endtask

  task automatic expect_req(input string name, input logic [7:0] tag, input logic e_hit,
                            input logic [1:0] e_buf, input int e_lat, input logic e_ev,
                            input logic [7:0] e_old);
    logic h, ev;
    logic [1:0] b;
    logic [7:0] old;
    int lat;
    do_req(tag, h, b, lat, ev, old);
    check({name, "_hit"}, 32'(h), 32'(e_hit));
    check({name, "_buf"}, 32'(b), 32'(e_buf));
    check({name, "_lat"}, 32'(lat), 32'(e_lat));
    if (!e_hit) begin
      check({name, "_evict"}, 32'(ev), 32'(e_ev));
      check({name, "_old"}, 32'(old), 32'(e_old));
    end
  endtask

  initial begin
    int got, prev, n, fc, rc;
    logic h, ev;
    logic [1:0] b;
    logic [7:0] old;
    int lat;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp", 32'(resp_valid), 32'd0);
    check("rst_ref", 32'(ref_valid), 32'd0);
    check("rst_refnum", 32'(ref_buf_numbr), 32'd0);
    check("rst_nbr", 32'(new_buf_req), 32'd0);
    check("rst_fill", 32'(fill_valid), 32'd0);
    rst = 1'b0;

    replc_fixed = 1;
    expect_req("first_miss", 8'h11, 1'b0, 2'd0, 2, 1'b0, 8'h00);
    check("first_refnum", 32'(ref_buf_numbr), 32'd0);
    expect_req("fill1", 8'h22, 1'b0, 2'd1, 2, 1'b0, 8'h00);
    expect_req("fill2", 8'h33, 1'b0, 2'd2, 2, 1'b0, 8'h00);
    expect_req("fill3", 8'h44, 1'b0, 2'd3, 2, 1'b0, 8'h00);
    check("no_nbr_while_free", 32'(nbr_count), 32'd0);
    expect_req("hit33", 8'h33, 1'b1, 2'd2, 1, 1'b0, 8'h00);
    check("hit33_refnum", 32'(ref_buf_numbr), 32'd2);

    expect_req("evict55", 8'h55, 1'b0, 2'd1, 3, 1'b1, 8'h22);
    check("nbr_once", 32'(nbr_count), 32'd1);
    replc_fixed = 2;
    expect_req("miss22", 8'h22, 1'b0, 2'd2, 3, 1'b1, 8'h33);
    expect_req("hit55", 8'h55, 1'b1, 2'd1, 1, 1'b0, 8'h00);

    // Back-to-back hits: directory is now 11,55,22,44.
    @(posedge clk); #2;
    req_valid = 1'b1; req_tag = 8'h11;
    got = 0; prev = -1; n = 0;
    while (got < 8 && n < 40) begin
      @(posedge clk); #2; n++;
      if (resp_valid === 1'b1) begin
        check("b2b_hit", 32'(resp_hit), 32'd1);
        check("b2b_buf", 32'(resp_buf), (got % 2 == 1) ? 32'd3 : 32'd0);
        if (prev >= 0) check("b2b_spacing", 32'(n - prev), 32'd2);
        prev = n; got++;
        req_tag = (got % 2 == 1) ? 8'h44 : 8'h11;
        if (got == 8) req_valid = 1'b0;
      end else begin
        check("b2b_busy_ready", 32'(req_ready), 32'd0);
      end
    end
    req_valid = 1'b0;
    check("b2b_count", 32'(got), 32'd8);

    // Reset while waiting on the LFU.
    replc_fixed = 1;
    @(posedge clk); #2;
    req_valid = 1'b1; req_tag = 8'h77;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    check("wait_nbr", 32'(new_buf_req), 32'd1);
    fc = fill_count; rc = ref_count;
    rst = 1'b1;
    @(posedge clk); #2;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    check("mid_rst_fill", 32'(fill_valid), 32'd0);
    check("mid_rst_ref", 32'(ref_valid), 32'd0);
    check("mid_rst_nbr", 32'(new_buf_req), 32'd0);
    check("mid_rst_refnum", 32'(ref_buf_numbr), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_rst_no_fill", 32'(fill_count), 32'(fc));
    check("mid_rst_no_ref", 32'(ref_count), 32'(rc));
    expect_req("post_rst", 8'h55, 1'b0, 2'd0, 2, 1'b0, 8'h00);

    // Random traffic over a small tag space to mix hits, fills and evictions.
    replc_fixed = -1;
    for (int i = 0; i < 250; i++) begin
      do_req(8'(8'h10 + $urandom_range(0, 7)), h, b, lat, ev, old);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/buf_tag_dir.md
Name: buf_tag_dir

Overview:
- Buffer tag directory sitting directly upstream of the LFU replacement unit.
- Takes tagged access requests and matches them against the tags held by the 4 buffers.
- On a hit, reports the hit buffer to the LFU through `ref_buf_numbr`.
- On a miss, fills a free buffer first. When no buffer is free it pulses `new_buf_req`, takes the LFU's `buf_num_replc` as the victim, installs the new tag there and drives the fill command to the buffer memory.

Parameters:
- NUM_BUF, 4, number of buffers; fixed to match the LFU.
- IDX_W, 2, buffer index width, equal to log2(NUM_BUF).
- TAG_W, 8, tag width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  access request valid.
- req_tag  in  TAG_W  tag of the requested block.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss with install; valid with resp_valid.
- resp_buf  out  IDX_W  buffer now holding the tag; valid with resp_valid.
- ref_valid  out  1  one-cycle pulse: buffer ref_buf_numbr was referenced.
- ref_buf_numbr  out  IDX_W  referenced buffer index to the LFU; holds its last value between pulses.
- new_buf_req  out  1  one-cycle replacement request to the LFU.
- buf_num_replc  in  IDX_W  victim index from the LFU.
- fill_valid  out  1  one-cycle install command to the buffer memory.
- fill_buf  out  IDX_W  buffer being installed.
- fill_tag  out  TAG_W  new tag.
- fill_evict  out  1  1 = a valid tag was overwritten.
- fill_old_tag  out  TAG_W  overwritten tag; 0 when fill_evict = 0.

Behaviour:
- State: tag[NUM_BUF], valid[NUM_BUF], latched request tag, victim index, FSM.
- Reset: all valid bits = 0, FSM = IDLE. All outputs = 0 except req_ready = 1.
- IDLE: req_ready = 1. On accept, latch req_tag and go to LOOKUP. req_tag is not sampled again until the next accept.
- LOOKUP (one cycle): compare the latched tag against every valid entry.
  - Hit at index h: resp_valid = 1, resp_hit = 1, resp_buf = h; ref_valid = 1, ref_buf_numbr = h; go to IDLE.
  - Miss with at least one invalid entry: victim = lowest invalid index; go to INSTALL. new_buf_req is not asserted.
  - Miss with all entries valid: new_buf_req = 1 for this cycle only; go to WAIT.
- WAIT (one cycle): victim = buf_num_replc, sampled in the cycle after the new_buf_req pulse; go to INSTALL.
- INSTALL (one cycle):
  - tag[victim] = latched tag, valid[victim] = 1.
  - fill_valid = 1, fill_buf = victim, fill_tag = latched tag.
  - fill_evict = previous valid[victim]; fill_old_tag = previous tag, or 0 when nothing was evicted.
  - ref_valid = 1, ref_buf_numbr = victim, so the LFU counts the install.
  - resp_valid = 1, resp_hit = 0, resp_buf = victim; go to IDLE.
- Latency from the accept edge to the resp_valid cycle: hit = 1 cycle; miss into a free buffer = 2; miss with eviction = 3.
- Throughput: at most one request in flight. req_valid while busy is ignored because req_ready = 0; the request is not lost, it is accepted once the FSM returns to IDLE.
- Tags are unique by construction, since install happens only on a miss. Hit index uses a priority encoder (lowest index) for robustness.
- All pulse outputs are registered decodes of the state and are low in every other cycle.
- Reset mid-operation (any state): the in-flight request is dropped with no response, no fill and no ref. Directory is cleared; next cycle is IDLE.

Decomposition:
- Package buf_tag_dir_pkg holds:
  - constants NUM_BUF and IDX_W;
  - FSM state enum IDLE / LOOKUP / WAIT / INSTALL, 2-bit encoding.
- Sub-module buf_tag_match: purely combinational. Takes tags, valid bits and the lookup tag. Produces hit, hit_idx, any_free and free_idx (lowest invalid index, priority-encoded).

Test Plan:
- Reset, then request 0x11 -> miss into free buffer 0. resp_valid 2 cycles after accept with resp_hit=0, resp_buf=0. fill_evict=0, ref_buf_numbr=0, new_buf_req never high.
- Install 0x11, 0x22, 0x33, 0x44 -> buffers 0, 1, 2, 3. Then request 0x33 -> hit 1 cycle after accept: resp_hit=1, resp_buf=2, ref_valid pulse with ref_buf_numbr=2.
- Directory full, request 0x55, LFU stub drives buf_num_replc=1 -> new_buf_req high for exactly 1 cycle (LOOKUP). INSTALL shows fill_buf=1, fill_evict=1, fill_old_tag=0x22. Afterwards 0x22 misses and 0x55 hits buffer 1.
- req_valid held high with alternating tags 0x11/0x44 (both resident) -> req_ready low while busy. One hit response every 2 cycles, no duplicate or missing responses.
- rst asserted during WAIT -> next cycle: req_ready=1 and every other output 0. No INSTALL, fill or ref occurs. A following request 0x55 misses into free buffer 0.
